mapper_mem_responder: RTL and testbench

//  Memory-side responder for slot mappers: consumes one mapper's output request
//  (ram_cs/addr/rnw/data) and runs a req/ack access on the shared memory port.

---
 rtl/mapper_pkg.sv | 15 +
 rtl/mapper_mem_timeout.sv | 28 ++
 rtl/mapper_mem_responder.sv | 98 +++++++++
 tb/tb_mapper_mem_responder.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mapper_pkg.sv
// Shared types for the mapper memory responder.
// Holds the FSM state encoding and the open-bus/unmapped constants.
package mapper_pkg;

  typedef enum logic [1:0] {
    MR_IDLE,
    MR_REQ,
    MR_DONE
  } mem_resp_state_t;

  // Single fill bit, replicated to the address width where used.
  localparam logic       UNMAPPED_ADDR = '1;
  localparam logic [7:0] OPEN_BUS      = 8'hFF;

endpackage

// File: rtl/mapper_mem_timeout.sv
// Abort counter for a pending memory request.
// Ports: clk, reset_n, clr, en in; expired out (cnt == TIMEOUT-1).
module mapper_mem_timeout #(
  parameter int TIMEOUT   = 255,
  parameter int TIMEOUT_W = 8
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [TIMEOUT_W-1:0] cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expired = (cnt == TIMEOUT_W'(TIMEOUT - 1));

endmodule

// File: rtl/mapper_mem_responder.sv
// Memory-side responder: turns one mapper request into a req/ack memory
// access. Ports: cpu_* / mapper side, mem_* arbiter side, timeout_err.
module mapper_mem_responder
  import mapper_pkg::*;
#(
  parameter int ADDR_W    = 27,
  parameter int DATA_W    = 8,
  parameter int TIMEOUT   = 255,
  parameter int TIMEOUT_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cpu_req,
  input  logic              ram_cs,
  input  logic [ADDR_W-1:0] addr,
  input  logic              rnw,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_wait,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              timeout_err
);

  localparam logic [ADDR_W-1:0] UNMAPPED = {ADDR_W{UNMAPPED_ADDR}};
  localparam logic [DATA_W-1:0] OPEN     = DATA_W'(OPEN_BUS);

  mem_resp_state_t state;
  logic            hit;
  logic            expired;

  assign hit = cpu_req && ram_cs && (addr != UNMAPPED);

  // Stall starts in the request cycle itself, ends on entry to DONE.
  assign cpu_wait = (hit && state == MR_IDLE) || (state == MR_REQ);

  mapper_mem_timeout #(
    .TIMEOUT  (TIMEOUT),
    .TIMEOUT_W(TIMEOUT_W)
  ) u_timeout (
    .clk    (clk),
    .reset_n(reset_n),
    .clr    (state != MR_REQ),
    .en     (state == MR_REQ),
    .expired(expired)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= MR_IDLE;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      cpu_rdata   <= OPEN;
      timeout_err <= 1'b0;
    end else begin
      case (state)
        MR_IDLE: begin
          if (hit) begin
            mem_addr  <= addr;
            mem_we    <= !rnw;
            mem_wdata <= wdata;
            mem_req   <= 1'b1;
            state     <= MR_REQ;
          end else if (cpu_req && rnw) begin
            cpu_rdata <= OPEN;
          end
        end
        MR_REQ: begin
          // Ack wins over expiry when both land together.
          if (mem_ack) begin
            mem_req <= 1'b0;
            if (!mem_we) cpu_rdata <= mem_rdata;
            state <= MR_DONE;
          end else if (expired) begin
            mem_req     <= 1'b0;
            timeout_err <= 1'b1;
            if (!mem_we) cpu_rdata <= OPEN;
            state <= MR_DONE;
          end
        end
        MR_DONE: state <= MR_IDLE;
        default: state <= MR_IDLE;
      endcase
    end
  end

  a_no_req_busy: assert property (
    @(posedge clk) disable iff (!reset_n)
    !(cpu_req && state != MR_IDLE)
  );

endmodule

// File: tb/tb_mapper_mem_responder.sv
// Scoreboard bench for mapper_mem_responder.
// Reference model + memory responder; monitor pops and compares.
module tb_mapper_mem_responder;

  localparam int AW = 27;
  localparam int DW = 8;
  localparam int T  = 4;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          cpu_req = 1'b0;
  logic          ram_cs = 1'b0;
  logic [AW-1:0] addr = '0;
  logic          rnw = 1'b1;
  logic [DW-1:0] wdata = '0;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_wait;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [DW-1:0] mem_wdata;
  logic          mem_ack = 1'b0;
  logic [DW-1:0] mem_rdata = '0;
  logic          timeout_err;

  mapper_mem_responder #(
    .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(T), .TIMEOUT_W(8)
  ) dut (
    .clk(clk), .reset_n(reset_n), .cpu_req(cpu_req), .ram_cs(ram_cs),
    .addr(addr), .rnw(rnw), .wdata(wdata), .cpu_rdata(cpu_rdata),
    .cpu_wait(cpu_wait), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] a;
    logic          we;
    logic [DW-1:0] wd;
    int            cyc;
  } req_t;

  typedef struct {
    logic [DW-1:0] rd;
    logic          err;
  } comp_t;

  req_t  req_q[$];
  comp_t comp_q[$];
  int    lat_q[$];

  logic [DW-1:0] mem [logic [AW-1:0]];
  logic [DW-1:0] m_rd = 8'hFF;
  logic          m_err = 1'b0;
  logic [AW-1:0] all1 = '1;

  int total = 0;
  int bad = 0;

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endfunction

  function automatic logic [DW-1:0] memval(logic [AW-1:0] a);
    if (mem.exists(a)) return mem[a];
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  // lat = cycle of mem_req on which memory acks; lat > T means never.
  task automatic issue(input logic cs, input logic [AW-1:0] a,
                       input logic r, input logic [DW-1:0] wd,
                       input int lat, input bit wait_done = 1);
    bit    h;
    int    n;
    req_t  rq;
    comp_t cp;
    h = cs && (a != all1);
    if (h) begin
      rq.a = a; rq.we = !r; rq.wd = wd;
      rq.cyc = (lat <= T) ? lat : T;
      req_q.push_back(rq);
      lat_q.push_back(lat);
      if (lat <= T) begin
        if (r) m_rd = memval(a);
        else mem[a] = wd;
      end else begin
        if (r) m_rd = 8'hFF;
        m_err = 1'b1;
      end
    end else if (r) begin
      m_rd = 8'hFF;
    end
    if (wait_done && (h || r)) begin
      cp.rd = m_rd; cp.err = m_err;
      comp_q.push_back(cp);
    end
    @(posedge clk); #1;
    cpu_req = 1'b1; ram_cs = cs; addr = a; rnw = r; wdata = wd;
    @(posedge clk); #1;
    cpu_req = 1'b0;
    ram_cs = 1'($urandom); addr = AW'($urandom);
    rnw = 1'($urandom); wdata = DW'($urandom);
    if (wait_done) begin
      n = 0;
      while (cpu_wait && n < 30) begin
        @(posedge clk); #1;
        n++;
      end
      if (n >= 30) chk("wait_bound", 1, 0);
    end
  endtask

  // Memory side: ack after the scheduled latency, stray ack after aborts.
  bit r_active = 0;
  int r_cnt = 0;
  int r_lat = 0;
  always @(negedge clk) begin
    mem_ack = 1'b0;
    if (!reset_n) begin
      r_active = 0;
    end else if (mem_req) begin
      if (!r_active) begin
        r_active = 1;
        r_cnt = 0;
        r_lat = (lat_q.size() > 0) ? lat_q.pop_front() : 99;
      end
      r_cnt++;
      if (r_cnt == r_lat) begin
        mem_ack = 1'b1;
        mem_rdata = memval(mem_addr);
      end
    end else if (r_active) begin
      r_active = 0;
      if (r_lat > T) begin
        mem_ack = 1'b1;
        mem_rdata = 8'h00;
      end
    end
  end

  task automatic pop_comp(input string nm);
    comp_t cp;
    if (comp_q.size() == 0) begin
      chk({nm, "_missing"}, 1, 0);
    end else begin
      cp = comp_q.pop_front();
      chk({nm, "_rdata"}, cpu_rdata, cp.rd);
      chk({nm, "_err"}, timeout_err, cp.err);
    end
  endtask

  bit   in_req = 0;
  bit   pend_miss = 0;
  int   hcnt = 0;
  req_t cur;
  always @(negedge clk) begin
    if (!reset_n) begin
      in_req = 0;
      pend_miss = 0;
    end else begin
      chk("cpu_wait", cpu_wait,
          mem_req || (cpu_req && ram_cs && addr != all1));
      if (pend_miss) begin
        pend_miss = 0;
        pop_comp("miss_rd");
      end
      if (cpu_req && rnw && !(ram_cs && addr != all1)) pend_miss = 1;
      if (mem_req && !in_req) begin
        in_req = 1;
        hcnt = 1;
        if (req_q.size() == 0) begin
          chk("req_unexpected", 1, 0);
        end else begin
          cur = req_q.pop_front();
          chk("mem_addr", mem_addr, cur.a);
          chk("mem_we", mem_we, cur.we);
          chk("mem_wdata", mem_wdata, cur.wd);
        end
      end else if (mem_req) begin
        hcnt++;
        chk("mem_stable", {mem_we, mem_wdata, mem_addr},
            {cur.we, cur.wd, cur.a});
      end else if (in_req) begin
        in_req = 0;
        chk("req_cycles", hcnt, cur.cyc);
        pop_comp("hit_done");
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [AW-1:0] a;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_cpu_rdata", cpu_rdata, 8'hFF);
    chk("rst_timeout_err", timeout_err, 0);
    chk("rst_cpu_wait", cpu_wait, 0);
    #2 reset_n = 1'b1;

    mem[27'h0012345] = 8'hA5;
    issue(1'b1, 27'h0012345, 1'b1, 8'h00, 3);
    issue(1'b1, 27'h0000010, 1'b0, 8'h3C, 1);
    issue(1'b1, all1, 1'b1, 8'h00, 1);
    issue(1'b0, 27'h0012345, 1'b1, 8'h00, 1);
    issue(1'b1, 27'h0012345, 1'b0, 8'h77, 1);
    issue(1'b1, 27'h0000055, 1'b1, 8'h00, 6);
    issue(1'b1, 27'h0000056, 1'b1, 8'h00, T);

    issue(1'b1, 27'h0000077, 1'b1, 8'h00, 6, 0);
    @(posedge clk); #2;
    reset_n = 1'b0;
    #1;
    chk("arst_mem_req", mem_req, 0);
    chk("arst_cpu_rdata", cpu_rdata, 8'hFF);
    chk("arst_timeout_err", timeout_err, 0);
    chk("arst_cpu_wait", cpu_wait, 0);
    m_rd = 8'hFF;
    m_err = 1'b0;
    repeat (2) @(posedge clk);
    #3 reset_n = 1'b1;
    mem[27'h0012345] = 8'hA5;
    issue(1'b1, 27'h0012345, 1'b1, 8'h00, 2);

    issue(1'b1, 27'h0000100, 1'b0, 8'h11, 2);
    issue(1'b1, 27'h0000100, 1'b1, 8'h00, 1);
    issue(1'b1, 27'h0000200, 1'b1, 8'h00, 2);

    repeat (300) begin
      case ($urandom_range(0, 5))
        0: a = all1;
        1, 2: a = AW'($urandom_range(0, 15));
        default: a = AW'($urandom);
      endcase
      repeat ($urandom_range(0, 2)) @(posedge clk);
      issue($urandom_range(0, 9) != 0, a, 1'($urandom),
            DW'($urandom), $urandom_range(1, T + 2));
    end

    repeat (8) @(posedge clk);
    #1;
    chk("req_q_empty", req_q.size(), 0);
    chk("comp_q_empty", comp_q.size(), 0);
    chk("lat_q_empty", lat_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
